// File: rtl/sequence_stepper_if.sv
// sequence_stepper_if: command inputs and display outputs of the sequence stepper
interface sequence_stepper_if #(
    parameter int DIGIT_W = 4,
    parameter int IDX_W   = 4
);
    logic [1:0]         cmd;
    logic               step_en;
    logic               auto_run;
    logic [DIGIT_W-1:0] out;
    logic [IDX_W-1:0]   index;
    logic               display_on;
    logic               wrap;

    modport master (output cmd, step_en, auto_run, input out, index, display_on, wrap);
    modport slave  (input cmd, step_en, auto_run, output out, index, display_on, wrap);
endinterface

// File: rtl/sequence_stepper.sv
// sequence_stepper: wrap-around digit-sequence stepper with Mealy look-ahead output; SEQUENCE_STEPPER_AUTO_STEP_EN adds periodic auto stepping
module sequence_stepper #(
    parameter int                         DIGIT_W  = 4,
    parameter int                         SEQ_LEN  = 9,
    parameter logic [SEQ_LEN*DIGIT_W-1:0] SEQ_INIT = 36'h620324157,
    parameter logic [DIGIT_W-1:0]         OFF_CODE = {DIGIT_W{1'b1}},
    parameter int                         PRESCALE = 50_000_000,
    parameter int                         IDX_W    = $clog2(SEQ_LEN)
) (
    input logic               clock,
    input logic               reset,
    sequence_stepper_if.slave sif
);
    typedef enum logic {RUN, OFF} mode_e;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(SEQ_LEN - 1);

    mode_e              mode_q, mode_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wrap_q, wrap_d;
    logic [1:0]         ecmd, acmd;
    logic               tick;
    logic [DIGIT_W-1:0] seq [SEQ_LEN];

    for (genvar i = 0; i < SEQ_LEN; i++) begin : g_seq
        assign seq[i] = SEQ_INIT[i*DIGIT_W +: DIGIT_W];
    end

    assign ecmd = sif.step_en ? sif.cmd : 2'b00;

`ifdef SEQUENCE_STEPPER_AUTO_STEP_EN
    localparam int PC_W = $clog2(PRESCALE);

    logic [PC_W-1:0] pc_q, pc_d;

    assign tick = mode_q == RUN && sif.auto_run && pc_q == PC_W'(PRESCALE - 1);
    assign pc_d = (mode_q != RUN || !sif.auto_run || ecmd != 2'b00 || tick) ? '0 : pc_q + 1'b1;

    // prescale counter; any explicit command restarts the auto-step period
    always_ff @(posedge clock or posedge reset) begin
        if (reset) pc_q <= '0;
        else       pc_q <= pc_d;
    end
`else
    logic unused_auto_run;

    assign tick            = 1'b0;
    assign unused_auto_run = sif.auto_run;
`endif

    assign acmd = (ecmd == 2'b00 && tick) ? 2'b10 : ecmd;

    // next mode/position, wrap flag and look-ahead digit for the applied command
    always_comb begin
        mode_d = mode_q;
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (mode_q == OFF) begin
            if (acmd == 2'b01 || acmd == 2'b10) begin
                mode_d = RUN;
                idx_d  = '0;
            end
        end else if (acmd == 2'b11) begin
            mode_d = OFF;
        end else if (acmd == 2'b10) begin
            idx_d  = (idx_q == LAST) ? '0 : idx_q + 1'b1;
            wrap_d = idx_q == LAST;
        end else if (acmd == 2'b01) begin
            idx_d  = (idx_q == '0) ? LAST : idx_q - 1'b1;
            wrap_d = idx_q == '0;
        end
        sif.out = reset ? seq[0] : (mode_d == OFF) ? OFF_CODE : seq[idx_d];
    end

    // mode, position and wrap pulse registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q <= RUN;
            idx_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
        end
    end

    assign sif.index      = idx_q;
    assign sif.display_on = mode_q == RUN;
    assign sif.wrap       = wrap_q;
endmodule

// File: doc/sequence_stepper.md
Name: sequence_stepper

Overview:
- Parametrised digit-sequence stepper for the 7-segment display path. Holds a constant sequence of SEQ_LEN digits, each DIGIT_W bits wide.
- Commands move a position pointer forward or back with wrap-around, hold it, or blank the display.
- Mealy look-ahead output: `out` shows the digit that the next clock edge will enter, so the display updates in the same cycle a command is applied.
- Sits between the debounced button/switch logic and the 7-segment decoder.

Parameters:
- DIGIT_W, 4, width of each digit and of `out`.
- SEQ_LEN, 9, number of digits in the sequence; legal range 2..64.
- SEQ_INIT, 36'h620324157, packed sequence of SEQ_LEN*DIGIT_W bits; digit i = SEQ_INIT[i*DIGIT_W +: DIGIT_W]. Default sequence is 7,5,1,4,2,3,0,2,6.
- OFF_CODE, {DIGIT_W{1'b1}}, code driven on `out` while blanked; the decoder treats it as all segments off.
- PRESCALE, 50_000_000, clock cycles per automatic step; legal range ≥ 2.
- IDX_W, $clog2(SEQ_LEN), width of the `index` output.

Ports:
- clock  input  1  system clock, rising edge active.
- reset  input  1  asynchronous, active-high.
- cmd  input  2  00 hold, 01 back, 10 forward, 11 blank.
- step_en  input  1  qualifies `cmd` for one cycle; when 0, cmd is treated as 00.
- auto_run  input  1  level; enables periodic automatic forward stepping.
- out  output  DIGIT_W  combinational Mealy digit code.
- index  output  IDX_W  registered current position.
- display_on  output  1  registered; 0 while in OFF.
- wrap  output  1  registered one-cycle pulse on the edge that wraps the pointer.

Behaviour:
- Reset is asynchronous, active-high, on `reset`; all sequential logic is clocked by `clock`.
- State: mode ∈ {RUN, OFF}, idx ∈ 0..SEQ_LEN-1, prescale count pc.
- Reset values: mode=RUN, idx=0, pc=0, wrap=0, display_on=1, index=0. While reset is held, out=digit[0].
- Effective command ecmd = step_en ? cmd : 00. An auto tick substitutes forward only when ecmd==00.
- Transitions in RUN:
  - 00: hold.
  - 10: idx = (idx==SEQ_LEN-1) ? 0 : idx+1.
  - 01: idx = (idx==0) ? SEQ_LEN-1 : idx-1.
  - 11: mode=OFF; idx is kept.
- Transitions in OFF:
  - 00 or 11: stay in OFF.
  - 01 or 10: mode=RUN, idx=0, no wrap pulse.
- wrap is 1 for exactly the cycle after a transition last→0 (forward) or 0→last (back), including wraps caused by auto ticks; otherwise 0.
- Mealy output:
  - out = OFF_CODE when the next mode is OFF.
  - Otherwise out = digit[next idx], where next idx is the transition result for the current ecmd (or auto tick).
  - The path from cmd/step_en to out is purely combinational, with zero-cycle latency.
- display_on and index reflect the registered state, with one-cycle latency after the edge.
- Non-power-of-two SEQ_LEN: idx never takes values ≥ SEQ_LEN; the wrap comparison uses SEQ_LEN-1, not the counter width.
- Reset mid-operation forces all state to the reset values immediately (asynchronous), including pc and any pending wrap pulse.

Optional Feature:
- Macro: SEQUENCE_STEPPER_AUTO_STEP_EN.
- Defined:
  - pc counts 0..PRESCALE-1 while mode==RUN and auto_run==1. Reaching PRESCALE-1 produces an auto tick that cycle, and pc returns to 0.
  - Any accepted non-00 ecmd clears pc to 0. A command on the tick cycle overrides the tick, so no double step occurs.
  - pc is held at 0 in OFF or when auto_run==0.
- Undefined:
  - No prescale counter is synthesised; auto_run is ignored and only commands move the pointer.
  - All other behaviour is identical.

Test Plan:
- Reset: release reset, apply no commands → index=0, out=7, display_on=1, wrap=0.
- Forward: nine step_en pulses with cmd=10 → out sequence 5,1,4,2,3,0,2,6,7; index returns to 0; wrap=1 only on the cycle after the ninth pulse.
- Back wrap: from idx=0, one pulse with cmd=01 → out=6 combinationally in that cycle, index=8 next cycle, wrap pulse 1 cycle.
- Blank: from idx=3, cmd=11 → out=15, display_on=0. Then cmd=11 again → stays in OFF. Then cmd=01 → out=7, index=0, wrap=0.
- Auto (macro on, PRESCALE=4, auto_run=1): forward ticks at cycles 4, 8, 12. A cmd=01 pulse at cycle 7 gives a back step and pc=0, so the next auto tick comes at cycle 11.
- Async reset at idx=5 mid-cycle → index=0, out=7, wrap=0 without waiting for a clock edge. With the macro on, pc=0.
